// File: rtl/conv_window_gen_if.sv
// Stream bundle for conv_window_gen: raster pixel input and flattened F x F window output.
// The slave modport is the window generator itself, and the master modport is its environment.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int F          = 3,
  parameter int W          = 8,
  parameter int H          = 8
);
  localparam int RW = ((H - F + 1) > 1) ? $clog2(H - F + 1) : 1;
  localparam int CW = ((W - F + 1) > 1) ? $clog2(W - F + 1) : 1;

  logic [DATA_WIDTH-1:0]       pixel_in;
  logic                        pixel_valid;
  logic                        pixel_ready;
  logic [0:F*F*DATA_WIDTH-1]   window;
  logic                        window_valid;
  logic                        window_ready;
  logic                        window_last;
  logic [RW-1:0]               out_row;
  logic [CW-1:0]               out_col;

  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window, window_valid, window_last, out_row, out_col
  );

  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window, window_valid, window_last, out_row, out_col
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding F x F window generator (stride 1, no padding) over a raster W x H pixel stream.
// It uses F-1 line buffers and a shift window, and holds each output window until downstream accepts it.
module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int F          = 3,
  parameter int W          = 8,
  parameter int H          = 8
) (
  input  logic              clk,
  input  logic              reset,
  conv_window_gen_if.slave  bus
);
  localparam int RW  = ((H - F + 1) > 1) ? $clog2(H - F + 1) : 1;
  localparam int CW  = ((W - F + 1) > 1) ? $clog2(W - F + 1) : 1;
  localparam int IRW = $clog2(H);
  localparam int ICW = $clog2(W);

  logic [ICW-1:0]            in_col_r;
  logic [IRW-1:0]            in_row_r;
  logic [DATA_WIDTH-1:0]     lbuf_r     [F-1][W];
  logic [DATA_WIDTH-1:0]     win_r      [F][F];
  logic [DATA_WIDTH-1:0]     win_next_s [F][F];
  logic [0:F*F*DATA_WIDTH-1] win_flat_s;
  logic                      accept_s;
  logic                      emit_s;
  logic                      col_end_s;
  logic                      row_end_s;

  // The single output slot can take a new window whenever it is empty or being drained this edge.
  assign bus.pixel_ready = !bus.window_valid || bus.window_ready;
  assign accept_s  = bus.pixel_valid && bus.pixel_ready;
  assign col_end_s = (in_col_r == ICW'(W - 1));
  assign row_end_s = (in_row_r == IRW'(H - 1));
  assign emit_s    = accept_s && (in_row_r >= IRW'(F - 1)) && (in_col_r >= ICW'(F - 1));

  // Next shift window: columns move left, new right column = line buffers over the incoming pixel.
  always_comb begin
    for (int wr = 0; wr < F; wr++) begin
      for (int wc = 0; wc < F - 1; wc++) begin
        win_next_s[wr][wc] = win_r[wr][wc+1];
      end
    end
    for (int wr = 0; wr < F - 1; wr++) begin
      win_next_s[wr][F-1] = lbuf_r[wr][in_col_r];
    end
    win_next_s[F-1][F-1] = bus.pixel_in;
  end

  // Flatten the next window so that element k = wr*F+wc lands at [DATA_WIDTH*k +: DATA_WIDTH].
  always_comb begin
    win_flat_s = '0;
    for (int wr = 0; wr < F; wr++) begin
      for (int wc = 0; wc < F; wc++) begin
        win_flat_s[DATA_WIDTH*(wr*F+wc) +: DATA_WIDTH] = win_next_s[wr][wc];
      end
    end
  end

  // Pixel storage; stale contents are always overwritten before they can reach an emitted window.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      win_r <= win_next_s;
      for (int j = 0; j < F - 2; j++) begin
        lbuf_r[j][in_col_r] <= lbuf_r[j+1][in_col_r];
      end
      lbuf_r[F-2][in_col_r] <= bus.pixel_in;
    end else begin
      win_r <= win_r;
    end
  end

  // Raster position of the next pixel to arrive; wraps straight into the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_col_r <= '0;
      in_row_r <= '0;
    end else if (accept_s) begin
      if (col_end_s) begin
        in_col_r <= '0;
        if (row_end_s) begin
          in_row_r <= '0;
        end else begin
          in_row_r <= in_row_r + IRW'(1);
        end
      end else begin
        in_col_r <= in_col_r + ICW'(1);
      end
    end else begin
      in_col_r <= in_col_r;
      in_row_r <= in_row_r;
    end
  end

  // Output slot: load on emit, clear on consume-without-replacement, otherwise hold bit-stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.window       <= '0;
      bus.window_valid <= 1'b0;
      bus.window_last  <= 1'b0;
      bus.out_row      <= '0;
      bus.out_col      <= '0;
    end else if (emit_s) begin
      bus.window       <= win_flat_s;
      bus.window_valid <= 1'b1;
      bus.window_last  <= row_end_s && col_end_s;
      bus.out_row      <= RW'(in_row_r - IRW'(F - 1));
      bus.out_col      <= CW'(in_col_r - ICW'(F - 1));
    end else if (bus.window_valid && bus.window_ready) begin
      bus.window_valid <= 1'b0;
      bus.window_last  <= 1'b0;
    end else begin
      bus.window_valid <= bus.window_valid;
      bus.window_last  <= bus.window_last;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and scoreboarded checks of conv_window_gen on a 5x5 image with a 3x3 window.
module tb_conv_window_gen;
  localparam int DW = 32;
  localparam int F  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int OW = W - F + 1;
  localparam int NP = W * H;
  localparam int NW = (H - F + 1) * (W - F + 1);
  localparam int WB = F * F * DW;

  typedef struct {
    logic [DW-1:0] pix;
    bit            wv;
    int            row;
    int            col;
    bit            last;
    bit            hand_en;
    int            hand[9];
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_WIDTH(DW), .F(F), .W(W), .H(H)) bus ();
  conv_window_gen #(.DATA_WIDTH(DW), .F(F), .W(W), .H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  vec_t vecs[NP];
  int bases[3];
  int nframes, send_idx, cons_idx, lasts, low_hits;
  bit check_low;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input logic [0:WB-1] act, input logic [0:WB-1] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [0:WB-1] win_at(input int base, input int row, input int col);
    logic [0:WB-1] w;
    w = '0;
    for (int wr = 0; wr < F; wr++)
      for (int wc = 0; wc < F; wc++)
        w[DW*(wr*F+wc) +: DW] = DW'(base + (row + wr) * W + col + wc + 1);
    return w;
  endfunction

  function automatic int pix_val(input int idx);
    return bases[idx / NP] + (idx % NP) + 1;
  endfunction

  task automatic consume();
    int f, k;
    logic [DW-1:0] v;
    if (cons_idx >= nframes * NW) begin
      chk("extra_window", 64'(cons_idx), 64'(nframes * NW - 1));
    end else begin
      f = cons_idx / NW;
      k = cons_idx % NW;
      chk_win("sb_window", bus.window, win_at(bases[f], k / OW, k % OW));
      chk("sb_row", 64'(bus.out_row), 64'(k / OW));
      chk("sb_col", 64'(bus.out_col), 64'(k % OW));
      chk("sb_last", 64'(bus.window_last), 64'(k == NW - 1));
    end
    if (bus.window_last) lasts++;
    if (check_low) begin
      for (int e = 0; e < F * F; e++) begin
        v = bus.window[DW*e +: DW];
        if (v >= 1 && v <= 15) low_hits++;
      end
    end
    cons_idx++;
  endtask

  // One clock: drive at post-edge, account handshakes at the falling edge, return just after the edge.
  task automatic step(input bit v, input bit r);
    bus.pixel_valid  = v && (send_idx < nframes * NP);
    bus.pixel_in     = bus.pixel_valid ? DW'(pix_val(send_idx)) : '0;
    bus.window_ready = r;
    @(negedge clk);
    if (bus.pixel_valid && bus.pixel_ready) send_idx++;
    if (bus.window_valid && bus.window_ready) consume();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input int n, input int b0, input int b1, input int b2);
    nframes = n;
    bases[0] = b0;
    bases[1] = b1;
    bases[2] = b2;
    send_idx = 0;
    cons_idx = 0;
    lasts = 0;
  endtask

  task automatic run_stream(input int vpct, input int rpct, input int budget, input string nm);
    int cyc = 0;
    while ((send_idx < nframes * NP || cons_idx < nframes * NW) && cyc < budget) begin
      step($urandom_range(99, 0) < vpct, $urandom_range(99, 0) < rpct);
      cyc++;
    end
    chk({nm, "_sent"}, 64'(send_idx), 64'(nframes * NP));
    chk({nm, "_windows"}, 64'(cons_idx), 64'(nframes * NW));
    chk({nm, "_lasts"}, 64'(lasts), 64'(nframes));
    chk({nm, "_idle_valid"}, 64'(bus.window_valid), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.window_ready = 1'b0;
    bus.pixel_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, sent_before;
    logic [0:WB-1] hw;

    for (int i = 0; i < NP; i++) begin
      vecs[i].pix     = DW'(i + 1);
      vecs[i].wv      = (i / W >= F - 1) && (i % W >= F - 1);
      vecs[i].row     = i / W - (F - 1);
      vecs[i].col     = i % W - (F - 1);
      vecs[i].last    = (i == NP - 1);
      vecs[i].hand_en = 1'b0;
      vecs[i].hand    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    end
    vecs[12].hand_en = 1'b1; vecs[12].hand = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    vecs[17].hand_en = 1'b1; vecs[17].hand = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    vecs[24].hand_en = 1'b1; vecs[24].hand = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    check_low = 1'b0;
    low_hits = 0;
    nframes = 0;

    reset = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.window_ready = 1'b0;
    bus.pixel_in = '0;
    #2;
    chk("rst_window_valid", 64'(bus.window_valid), 64'd0);
    chk("rst_window_last", 64'(bus.window_last), 64'd0);
    chk("rst_out_row", 64'(bus.out_row), 64'd0);
    chk("rst_out_col", 64'(bus.out_col), 64'd0);
    chk_win("rst_window", bus.window, '0);
    chk("rst_pixel_ready", 64'(bus.pixel_ready), 64'd1);
    do_reset();

    // Full-rate frame 1..25 from the vector table, including back-to-back window loads.
    for (int i = 0; i < NP; i++) begin
      bus.pixel_in = vecs[i].pix;
      bus.pixel_valid = 1'b1;
      bus.window_ready = 1'b1;
      @(negedge clk);
      chk("tbl_pixel_ready", 64'(bus.pixel_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("tbl_window_valid", 64'(bus.window_valid), 64'(vecs[i].wv));
      chk("tbl_window_last", 64'(bus.window_last), 64'(vecs[i].last));
      if (vecs[i].wv) begin
        chk("tbl_out_row", 64'(bus.out_row), 64'(vecs[i].row));
        chk("tbl_out_col", 64'(bus.out_col), 64'(vecs[i].col));
        chk_win("tbl_window", bus.window, win_at(0, vecs[i].row, vecs[i].col));
      end
      if (vecs[i].hand_en) begin
        for (int e = 0; e < F * F; e++) hw[DW*e +: DW] = DW'(vecs[i].hand[e]);
        chk_win("tbl_hand_window", bus.window, hw);
      end
    end
    bus.pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tbl_drain_valid", 64'(bus.window_valid), 64'd0);
    chk("tbl_drain_last", 64'(bus.window_last), 64'd0);

    // Backpressure: stall the first window for 6 cycles.
    do_reset();
    start_stream(1, 0, 0, 0);
    guard = 0;
    while (!bus.window_valid && guard < 100) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("bp_first_valid", 64'(bus.window_valid), 64'd1);
    sent_before = send_idx;
    for (int s = 0; s < 6; s++) begin
      step(1'b1, 1'b0);
      chk_win("bp_stall_window", bus.window, win_at(0, 0, 0));
      chk("bp_stall_pixel_ready", 64'(bus.pixel_ready), 64'd0);
      chk("bp_stall_row", 64'(bus.out_row), 64'd0);
      chk("bp_stall_col", 64'(bus.out_col), 64'd0);
    end
    chk("bp_no_pixel_taken", 64'(send_idx), 64'(sent_before));
    run_stream(100, 100, 300, "bp");

    // Random gaps on both sides across 3 back-to-back frames.
    do_reset();
    start_stream(3, 200, 300, 400);
    run_stream(70, 70, 3000, "rand");

    // Asynchronous reset mid-frame, then a fresh frame 101..125.
    do_reset();
    start_stream(1, 0, 0, 0);
    guard = 0;
    while (send_idx < 15 && guard < 100) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("mid_valid_before_reset", 64'(bus.window_valid), 64'd1);
    bus.pixel_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.window_valid), 64'd0);
    chk("mid_rst_last", 64'(bus.window_last), 64'd0);
    chk("mid_rst_row", 64'(bus.out_row), 64'd0);
    chk("mid_rst_col", 64'(bus.out_col), 64'd0);
    chk_win("mid_rst_window", bus.window, '0);
    chk("mid_rst_pixel_ready", 64'(bus.pixel_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    start_stream(1, 100, 0, 0);
    check_low = 1'b1;
    low_hits = 0;
    run_stream(100, 100, 300, "rst");
    chk("rst_no_stale_values", 64'(low_hits), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
